icache: RTL and testbench
=========================

Name: icache

Overview:
- Direct-mapped instruction cache between the PC/instruction queue (iq) and the memory fetcher (fc).
- Holds the fetch PC and looks it up each cycle. A hit delivers the instruction word to iq.
- A miss posts a single-word instruction request into fc, then waits for fc's commit with the instruction flag set, fills the line and forwards the word.
- A ROB exception redirects the PC and abandons any outstanding miss.

Parameters:
- Entries, 64, number of cache lines (one 32-bit word per line); power of two.
- IndexLength, 5, index width minus one (log2(Entries)-1).
- FlushCycles, 2, cycles after an exception during which fc commits are ignored.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low, all state holds.
- is_exception_from_rob  in  1  redirect or flush request.
- pc_from_rob  in  32  redirect target; valid with is_exception_from_rob.
- is_ready_from_iq  in  1  iq can accept one instruction this cycle.
- is_valid_to_iq  out  1  one-cycle pulse: instr_to_iq and pc_to_iq are valid.
- instr_to_iq  out  32  instruction word.
- pc_to_iq  out  32  PC of that instruction.
- is_ready_from_fc  in  1  fc buffer has room.
- is_empty_to_fc  out  1  low = request valid this cycle (one-cycle low pulse).
- addr_to_fc  out  32  requested instruction address.
- is_commit_from_fc  in  1  fc completion pulse.
- is_instr_from_fc  in  1  the completion is an instruction fetch.
- data_from_fc  in  32  completed word, little-endian.

Behaviour:
- Reset (rst low, async) clears:
  - pc = 0, state = IDLE, all line valid bits = 0, flush counter = 0.
  - is_valid_to_iq = 0, is_empty_to_fc = 1, instr_to_iq = 0, pc_to_iq = 0, addr_to_fc = 0.
  - Reset mid-miss simply drops the miss; a later fc commit is ignored because state is IDLE.
- Address split:
  - index = pc[IndexLength+2:2]; tag = pc[31:IndexLength+3]; pc[1:0] is always 0.
- All outputs are registered. is_valid_to_iq and is_empty_to_fc auto-return to 0 and 1 respectively after one cycle.
- States: IDLE, MISS_REQ, MISS_WAIT, FLUSH.
  - IDLE:
    - If is_ready_from_iq, look up pc.
    - Hit: next cycle is_valid_to_iq = 1 with the line data and pc; pc += 4. A hit can be delivered every cycle.
    - Miss: go to MISS_REQ.
    - If is_ready_from_iq is low: no lookup, no state change.
  - MISS_REQ:
    - When is_ready_from_fc is high: drive is_empty_to_fc = 0 and addr_to_fc = pc for exactly one cycle, then go to MISS_WAIT.
    - Otherwise wait.
  - MISS_WAIT:
    - On is_commit_from_fc && is_instr_from_fc: write data_from_fc into the line, set its tag, set valid.
    - Same edge: is_valid_to_iq = 1 with that word and pc; pc += 4; go to IDLE.
    - Commits with is_instr_from_fc = 0 (load/store completions) are ignored.
  - FLUSH:
    - Counts FlushCycles cycles and ignores every fc commit, so a stale instruction returned in flight cannot be delivered.
    - Then go to IDLE.
- Exception, in any state: highest priority.
  - pc = pc_from_rob; is_valid_to_iq forced 0 that cycle; is_empty_to_fc forced 1.
  - Go to FLUSH if the state was MISS_REQ or MISS_WAIT, else to IDLE.
  - Cache contents are kept.
- Simultaneous events:
  - Exception together with a matching commit: the exception wins; the line is still filled (the data is correct for its address), but nothing is forwarded.
- pc wraps modulo 2^32.
- rdy low:
  - Freezes state, pc and the array; pulse outputs hold their current value.
  - A commit that arrives during rdy low is lost; fc is likewise frozen under rdy, so this does not occur in the system.
- At most one outstanding fc request exists at any time.

Decomposition:
- The shared parameters include file supplies the existing True/False/Zero and PcLength/DataLength constants.
- Add to it the state encodings IC_IDLE, IC_MISS_REQ, IC_MISS_WAIT, IC_FLUSH.
- One natural sub-module: icache_array (data/tag/valid storage with one combinational read port and one write port, plus valid-clear on reset).

Test Plan:
- Reset then is_ready_from_iq = 1, is_ready_from_fc = 1:
  - request pulse with addr_to_fc = 0x0;
  - commit with data 0x00000513 → is_valid_to_iq pulse with instr 0x00000513, pc 0x0;
  - next request for 0x4.
- Sequential code 0x0–0x1C filled once; after a redirect to 0x0:
  - eight back-to-back hits, one per cycle, pc_to_iq = 0x0, 0x4, …, 0x1C;
  - no fc requests.
- Conflict: fill 0x0, then fetch 0x100 (same index, Entries = 64) → miss. Fetching 0x0 again → miss.
- Exception to 0x80 during MISS_WAIT for 0x10; fc commit arrives one cycle later:
  - no is_valid_to_iq;
  - after 2 cycles, a request for 0x80.
- Load completion (commit with is_instr = 0) during MISS_WAIT → ignored; the following instr commit is delivered.
- is_ready_from_fc = 0 for 5 cycles in MISS_REQ → is_empty_to_fc stays 1; it pulses low on the first ready cycle.
- rst asserted mid-miss → all outputs at reset values immediately (asynchronously).

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared constants and state encoding for the instruction cache.
package icache_pkg;
  localparam logic True = 1'b1;
  localparam logic False = 1'b0;
  localparam int PcLength = 32;
  localparam int DataLength = 32;
  localparam logic [31:0] Zero = 32'h0;
  typedef enum logic [1:0] {
    IC_IDLE,
    IC_MISS_REQ,
    IC_MISS_WAIT,
    IC_FLUSH
  } ic_state_e;
endpackage

// File: rtl/icache_array.sv
// icache_array: direct-mapped data/tag/valid storage, combinational read, single write port.
module icache_array
  import icache_pkg::*;
#(
  parameter int Entries = 64,
  parameter int IndexLength = 5,
  parameter int TagW = PcLength - IndexLength - 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IndexLength:0]  rd_idx_i,
  input  logic [TagW-1:0]       rd_tag_i,
  output logic                  hit_o,
  output logic [DataLength-1:0] rd_data_o,
  input  logic                  we_i,
  input  logic [IndexLength:0]  wr_idx_i,
  input  logic [TagW-1:0]       wr_tag_i,
  input  logic [DataLength-1:0] wr_data_i
);
  logic [DataLength-1:0] data_q [Entries];
  logic [TagW-1:0]       tag_q  [Entries];
  logic [Entries-1:0]    valid_q;

  assign hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_idx_i];

  always_ff @(posedge clk or negedge rst)
    if (!rst) valid_q <= '0;
    else if (we_i) valid_q[wr_idx_i] <= True;

  // Payload needs no reset: it is never observed while its valid bit is clear.
  always_ff @(posedge clk)
    if (we_i) begin
      data_q[wr_idx_i] <= wr_data_i;
      tag_q[wr_idx_i]  <= wr_tag_i;
    end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache between the PC/instruction queue and the memory fetcher.
module icache
  import icache_pkg::*;
#(
  parameter int Entries = 64,
  parameter int IndexLength = 5,
  parameter int FlushCycles = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  is_exception_from_rob,
  input  logic [PcLength-1:0]   pc_from_rob,
  input  logic                  is_ready_from_iq,
  output logic                  is_valid_to_iq,
  output logic [DataLength-1:0] instr_to_iq,
  output logic [PcLength-1:0]   pc_to_iq,
  input  logic                  is_ready_from_fc,
  output logic                  is_empty_to_fc,
  output logic [PcLength-1:0]   addr_to_fc,
  input  logic                  is_commit_from_fc,
  input  logic                  is_instr_from_fc,
  input  logic [DataLength-1:0] data_from_fc
);
  localparam int TagW = PcLength - IndexLength - 3;
  localparam int CntW = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;

  ic_state_e             state_q, state_d;
  logic [PcLength-1:0]   pc_q, pc_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  empty_q, empty_d;
  logic [DataLength-1:0] instr_q, instr_d;
  logic [PcLength-1:0]   pc_iq_q, pc_iq_d;
  logic [PcLength-1:0]   addr_q, addr_d;
  logic                  hit, fill;
  logic [DataLength-1:0] rd_data;

  // A matching commit fills the line even if an exception drops the delivery.
  assign fill = (state_q == IC_MISS_WAIT) && is_commit_from_fc && is_instr_from_fc;

  icache_array #(.Entries(Entries), .IndexLength(IndexLength), .TagW(TagW)) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_idx_i  (pc_q[IndexLength+2:2]),
    .rd_tag_i  (pc_q[PcLength-1:IndexLength+3]),
    .hit_o     (hit),
    .rd_data_o (rd_data),
    .we_i      (rdy && fill),
    .wr_idx_i  (pc_q[IndexLength+2:2]),
    .wr_tag_i  (pc_q[PcLength-1:IndexLength+3]),
    .wr_data_i (data_from_fc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    valid_d = False;
    empty_d = True;
    instr_d = instr_q;
    pc_iq_d = pc_iq_q;
    addr_d  = addr_q;
    case (state_q)
      IC_IDLE:
        if (is_ready_from_iq) begin
          if (hit) begin
            valid_d = True;
            instr_d = rd_data;
            pc_iq_d = pc_q;
            pc_d    = pc_q + 32'd4;
          end else state_d = IC_MISS_REQ;
        end
      IC_MISS_REQ:
        if (is_ready_from_fc) begin
          empty_d = False;
          addr_d  = pc_q;
          state_d = IC_MISS_WAIT;
        end
      IC_MISS_WAIT:
        if (fill) begin
          valid_d = True;
          instr_d = data_from_fc;
          pc_iq_d = pc_q;
          pc_d    = pc_q + 32'd4;
          state_d = IC_IDLE;
        end
      default: begin
        cnt_d   = (cnt_q == CntW'(FlushCycles - 1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CntW'(FlushCycles - 1)) ? IC_IDLE : IC_FLUSH;
      end
    endcase
    if (is_exception_from_rob) begin
      pc_d    = pc_from_rob;
      valid_d = False;
      empty_d = True;
      cnt_d   = '0;
      state_d = (state_q == IC_MISS_REQ || state_q == IC_MISS_WAIT) ? IC_FLUSH : IC_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IC_IDLE;
      pc_q    <= Zero;
      cnt_q   <= '0;
      valid_q <= False;
      empty_q <= True;
      instr_q <= Zero;
      pc_iq_q <= Zero;
      addr_q  <= Zero;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      empty_q <= empty_d;
      instr_q <= instr_d;
      pc_iq_q <= pc_iq_d;
      addr_q  <= addr_d;
    end

  assign is_valid_to_iq = valid_q;
  assign is_empty_to_fc = empty_q;
  assign instr_to_iq    = instr_q;
  assign pc_to_iq       = pc_iq_q;
  assign addr_to_fc     = addr_q;
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed scenarios plus a randomized run against a memory/cache-content reference model.
module tb_icache;
  logic clk = 0, rst = 0, rdy = 1, exc = 0, rdy_iq = 0, rdy_fc = 0, cmt = 0, ins = 0;
  logic [31:0] pc_rob = 0, dat = 0;
  logic is_valid_to_iq, is_empty_to_fc;
  logic [31:0] instr_to_iq, pc_to_iq, addr_to_fc;
  int n_chk = 0, n_fail = 0;
  bit saw_valid = 0;
  logic [31:0] mc_a [64];
  bit mc_v [64];

  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .is_exception_from_rob(exc), .pc_from_rob(pc_rob),
    .is_ready_from_iq(rdy_iq), .is_valid_to_iq(is_valid_to_iq),
    .instr_to_iq(instr_to_iq), .pc_to_iq(pc_to_iq),
    .is_ready_from_fc(rdy_fc), .is_empty_to_fc(is_empty_to_fc), .addr_to_fc(addr_to_fc),
    .is_commit_from_fc(cmt), .is_instr_from_fc(ins), .data_from_fc(dat)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h00000513;
  endfunction

  function automatic int ix(input logic [31:0] a);
    return int'((a >> 2) & 32'h3F);
  endfunction

  function automatic bit resident(input logic [31:0] a);
    return mc_v[ix(a)] && mc_a[ix(a)] == a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] a);
    int n = 0;
    while (is_empty_to_fc !== 1'b0 && n < 40) begin
      if (is_valid_to_iq === 1'b1) saw_valid = 1;
      tick();
      n++;
    end
    chk1({tag, "_req_seen"}, is_empty_to_fc, 1'b0);
    chk({tag, "_req_addr"}, addr_to_fc, a);
  endtask

  task automatic commit(input logic [31:0] d, input logic i);
    cmt = 1;
    ins = i;
    dat = d;
    tick();
    cmt = 0;
    ins = 0;
  endtask

  task automatic deliver(input string tag, input logic [31:0] a);
    commit(mem(a), 1'b1);
    chk1({tag, "_valid"}, is_valid_to_iq, 1'b1);
    chk({tag, "_instr"}, instr_to_iq, mem(a));
    chk({tag, "_pc"}, pc_to_iq, a);
    chk1({tag, "_empty_back"}, is_empty_to_fc, 1'b1);
  endtask

  task automatic serve(input string tag, input logic [31:0] a);
    wait_req(tag, a);
    deliver(tag, a);
  endtask

  task automatic exc_to(input logic [31:0] a);
    exc = 1;
    pc_rob = a;
    tick();
    exc = 0;
  endtask

  initial begin
    bit bad;
    int n;
    #12;
    chk1("rst_valid", is_valid_to_iq, 1'b0);
    chk1("rst_empty", is_empty_to_fc, 1'b1);
    chk("rst_instr", instr_to_iq, 32'h0);
    chk("rst_pc", pc_to_iq, 32'h0);
    chk("rst_addr", addr_to_fc, 32'h0);
    tick();
    rst = 1;
    rdy_iq = 1;
    rdy_fc = 1;
    // first miss from reset
    wait_req("first", 32'h0);
    commit(32'h00000513, 1'b1);
    chk1("first_valid", is_valid_to_iq, 1'b1);
    chk("first_instr", instr_to_iq, 32'h00000513);
    chk("first_pc", pc_to_iq, 32'h0);
    tick();
    chk1("valid_one_cycle", is_valid_to_iq, 1'b0);
    for (int a = 4; a < 32; a += 4) serve("seq", 32'(a));
    // redirect to 0: eight back-to-back hits, no requests
    exc_to(32'h0);
    n = 0;
    while (is_valid_to_iq !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    for (int k = 0; k < 8; k++) begin
      chk1("hit_valid", is_valid_to_iq, 1'b1);
      chk("hit_pc", pc_to_iq, 32'(4 * k));
      chk("hit_instr", instr_to_iq, mem(32'(4 * k)));
      chk1("hit_no_req", is_empty_to_fc, 1'b1);
      tick();
    end
    serve("after_hits", 32'h20);
    // conflict on index 0
    exc_to(32'h100);
    serve("conflict_100", 32'h100);
    exc_to(32'h0);
    serve("conflict_0", 32'h0);
    // exception during MISS_WAIT with a stale commit
    exc_to(32'h210);
    wait_req("stale_miss", 32'h210);
    exc_to(32'h80);
    chk1("exc_no_valid", is_valid_to_iq, 1'b0);
    commit(mem(32'h210), 1'b1);
    chk1("stale_ignored", is_valid_to_iq, 1'b0);
    saw_valid = 0;
    wait_req("after_flush", 32'h80);
    chk1("flush_no_valid", saw_valid, 1'b0);
    deliver("after_flush", 32'h80);
    // load completion ignored
    wait_req("load", 32'h84);
    commit(32'hDEADBEEF, 1'b0);
    chk1("load_ignored", is_valid_to_iq, 1'b0);
    deliver("load", 32'h84);
    // fc not ready for several cycles
    rdy_fc = 0;
    bad = 0;
    repeat (6) begin
      tick();
      if (is_empty_to_fc !== 1'b1) bad = 1;
    end
    chk1("fc_stall_no_req", bad, 1'b0);
    rdy_fc = 1;
    tick();
    chk1("fc_ready_req", is_empty_to_fc, 1'b0);
    chk("fc_ready_addr", addr_to_fc, 32'h88);
    deliver("fc_ready", 32'h88);
    // rdy low freezes pulse outputs
    rdy = 0;
    repeat (3) tick();
    chk1("rdy_hold_valid", is_valid_to_iq, 1'b1);
    chk("rdy_hold_pc", pc_to_iq, 32'h88);
    rdy = 1;
    tick();
    chk1("rdy_resume_valid", is_valid_to_iq, 1'b0);
    // asynchronous reset mid-miss
    wait_req("rst_mid", 32'h8C);
    rst = 0;
    #2;
    chk1("arst_empty", is_empty_to_fc, 1'b1);
    chk("arst_addr", addr_to_fc, 32'h0);
    chk1("arst_valid", is_valid_to_iq, 1'b0);
    chk("arst_instr", instr_to_iq, 32'h0);
    chk("arst_pc", pc_to_iq, 32'h0);
    tick();
    rst = 1;
    commit(mem(32'h8C), 1'b1);
    chk1("post_rst_commit_ignored", is_valid_to_iq, 1'b0);
    wait_req("post_rst_cleared", 32'h0);
    // randomized run against the reference model
    rst = 0;
    rdy_iq = 0;
    rdy_fc = 0;
    tick();
    rst = 1;
    begin
      bit pending = 0, c_last = 0, e_last = 0;
      logic [31:0] pend_addr = 0, t_last = 0, exp_pc = 0, t;
      int lat = 0, delivered = 0;
      for (int i = 0; i < 64; i++) mc_v[i] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (c_last) chk1("r_fill_delivers", is_valid_to_iq, 1'b1);
        if (is_valid_to_iq === 1'b1) begin
          chk("r_pc", pc_to_iq, exp_pc);
          chk("r_instr", instr_to_iq, mem(pc_to_iq));
          if (!c_last) chk1("r_hit_resident", resident(pc_to_iq), 1'b1);
          mc_v[ix(pc_to_iq)] = 1;
          mc_a[ix(pc_to_iq)] = pc_to_iq;
          exp_pc += 4;
          delivered++;
        end
        if (c_last) pending = 0;
        if (is_empty_to_fc === 1'b0) begin
          chk1("r_one_outstanding", pending, 1'b0);
          chk("r_req_addr", addr_to_fc, exp_pc);
          chk1("r_req_is_miss", resident(addr_to_fc), 1'b0);
          pending = 1;
          pend_addr = addr_to_fc;
          lat = int'($urandom_range(1, 4));
        end
        if (e_last) exp_pc = t_last;
        c_last = 0;
        e_last = 0;
        cmt = 0;
        ins = 0;
        exc = 0;
        if (pending) begin
          if (lat == 0) begin
            cmt = 1;
            ins = 1;
            dat = mem(pend_addr);
            c_last = 1;
          end else begin
            lat--;
            if ($urandom_range(0, 4) == 0) begin
              cmt = 1;
              dat = $urandom;
            end
          end
        end else if ($urandom_range(0, 19) == 0) begin
          t = 32'($urandom_range(0, 255)) << 2;
          exc = 1;
          pc_rob = t;
          e_last = 1;
          t_last = t;
        end
        rdy_iq = ($urandom_range(0, 4) != 0);
        rdy_fc = ($urandom_range(0, 3) != 0);
        tick();
      end
      chk1("r_progress", delivered > 200, 1'b1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
